// File: rtl/sram_arbiter.sv
// Two-master AXI4-Lite arbiter (IFU read-only, LSU read/write) onto one SRAM slave port.
// Latency: one arbitration cycle from request to slave valid, then channels routed combinationally.
// Backpressure: whole-transaction grant; the loser's readies stay 0 until one idle bubble after the response.
// SRAM_ARB_RR_EN selects round-robin between IFU and LSU; otherwise LSU has fixed priority.
module sram_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic        lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic        s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic        s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFU_RD = 2'd1;
    localparam logic [1:0] LSU_RD = 2'd2;
    localparam logic [1:0] LSU_WR = 2'd3;

    logic [1:0] state;
    logic       ar_done;
    logic       aw_done;
    logic       w_done;

    logic       is_ifu;
    logic       is_lrd;
    logic       is_lwr;
    logic       ifu_req;
    logic       lsu_rd_req;
    logic       lsu_wr_req;
    logic       lsu_req;
    logic       ifu_wins;
    logic [1:0] grant_state;

    assign is_ifu = (state == IFU_RD);
    assign is_lrd = (state == LSU_RD);
    assign is_lwr = (state == LSU_WR);

    assign ifu_req    = ifu_arvalid;
    assign lsu_rd_req = lsu_arvalid;
    assign lsu_wr_req = lsu_awvalid | lsu_wvalid;
    assign lsu_req    = lsu_rd_req | lsu_wr_req;

`ifdef SRAM_ARB_RR_EN
    logic last_grant;  // 1: LSU owned the previous transaction, 0: IFU

    assign ifu_wins = ifu_req & (~lsu_req | last_grant);
`else
    assign ifu_wins = ifu_req & ~lsu_req;
`endif

    // LSU read beats LSU write when both are pending
    assign grant_state = ifu_wins   ? IFU_RD :
                         lsu_rd_req ? LSU_RD :
                         lsu_wr_req ? LSU_WR : IDLE;

    // Read path: only one of IFU/LSU can own it at a time
    assign s_arvalid   = ((is_ifu & ifu_arvalid) | (is_lrd & lsu_arvalid)) & ~ar_done;
    assign s_araddr    = is_ifu ? ifu_araddr : (is_lrd ? lsu_araddr : 32'h0);
    assign ifu_arready = is_ifu & s_arready & ~ar_done;
    assign lsu_arready = is_lrd & s_arready & ~ar_done;
    assign ifu_rvalid  = is_ifu & s_rvalid;
    assign lsu_rvalid  = is_lrd & s_rvalid;
    assign s_rready    = (is_ifu & ifu_rready) | (is_lrd & lsu_rready);
    assign ifu_rdata   = s_rdata;
    assign ifu_rresp   = s_rresp;
    assign lsu_rdata   = s_rdata;
    assign lsu_rresp   = s_rresp;

    // Write path: AW and W complete independently, B closes the transaction
    assign s_awvalid   = is_lwr & lsu_awvalid & ~aw_done;
    assign lsu_awready = is_lwr & s_awready & ~aw_done;
    assign s_wvalid    = is_lwr & lsu_wvalid & ~w_done;
    assign lsu_wready  = is_lwr & s_wready & ~w_done;
    assign s_awaddr    = is_lwr ? lsu_awaddr : 32'h0;
    assign s_wdata     = is_lwr ? lsu_wdata  : 32'h0;
    assign s_wstrb     = is_lwr ? lsu_wstrb  : 4'h0;
    assign lsu_bvalid  = is_lwr & s_bvalid;
    assign s_bready    = is_lwr & lsu_bready;
    assign lsu_bresp   = s_bresp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= grant_state;
`ifdef SRAM_ARB_RR_EN
                    if (grant_state != IDLE)
                        last_grant <= ~ifu_wins;
`endif
                end
                IFU_RD, LSU_RD: begin
                    if (s_arvalid && s_arready)
                        ar_done <= 1'b1;
                    if (s_rvalid && s_rready) begin
                        state   <= IDLE;
                        ar_done <= 1'b0;
                    end
                end
                default: begin
                    if (s_awvalid && s_awready)
                        aw_done <= 1'b1;
                    if (s_wvalid && s_wready)
                        w_done <= 1'b1;
                    if (s_bvalid && s_bready) begin
                        state   <= IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
